// File: rtl/hilo_unit_if.sv
// Bus between the control unit / mult / div side and the HI/LO register unit.
interface hilo_unit_if;
  logic        OpStart;
  logic        OpSel;
  logic        MultStart;
  logic        MultStop;
  logic [31:0] MultHI;
  logic [31:0] MultLO;
  logic        DivStart;
  logic        DivStop;
  logic        DivZero;
  logic [31:0] DivHI;
  logic [31:0] DivLO;
  logic        WrHI;
  logic        WrLO;
  logic [31:0] WrData;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        DivZeroExc;
  logic        TimeoutExc;

  modport master (
    output OpStart, OpSel, MultStop, MultHI, MultLO,
           DivStop, DivZero, DivHI, DivLO, WrHI, WrLO, WrData,
    input  MultStart, DivStart, HI, LO, Busy, Done, DivZeroExc, TimeoutExc
  );

  modport slave (
    input  OpStart, OpSel, MultStop, MultHI, MultLO,
           DivStop, DivZero, DivHI, DivLO, WrHI, WrLO, WrData,
    output MultStart, DivStart, HI, LO, Busy, Done, DivZeroExc, TimeoutExc
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: launches mult/div, captures results, serves mthi/mtlo,
// and turns divide-by-zero / hung-unit conditions into exception pulses.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic       Clock,
  input  logic       Reset,
  hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam int unsigned CW = $clog2(TIMEOUT);

  state_t        state, state_nx;
  logic          sel;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_r, lo_r;
  logic          zexc_r, texc_r;

  logic          sel_stop;
  logic [31:0]   sel_hi, sel_lo;
  logic          abort_zero, load_result, abort_timeout;

  // Selected-unit view and WAIT-state event decode in priority order.
  always_comb begin
    sel_stop      = sel ? bus.DivStop : bus.MultStop;
    sel_hi        = sel ? bus.DivHI   : bus.MultHI;
    sel_lo        = sel ? bus.DivLO   : bus.MultLO;
    abort_zero    = (state == WAIT) && sel && bus.DivZero;
    load_result   = (state == WAIT) && !abort_zero && sel_stop;
    abort_timeout = (state == WAIT) && !abort_zero && !sel_stop &&
                    (cnt == CW'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.OpStart) state_nx = START;
      START:   state_nx = WAIT;
      WAIT: begin
        if (abort_zero || abort_timeout) state_nx = IDLE;
        else if (load_result)            state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: op select latch, wait counter, HI/LO registers, exception pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel    <= 1'b0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      zexc_r <= 1'b0;
      texc_r <= 1'b0;
    end else begin
      zexc_r <= abort_zero;
      texc_r <= abort_timeout;
      if (state == IDLE) begin
        if (bus.OpStart) sel  <= bus.OpSel;
        if (bus.WrHI)    hi_r <= bus.WrData;
        if (bus.WrLO)    lo_r <= bus.WrData;
      end
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      if (load_result) begin
        hi_r <= sel_hi;
        lo_r <= sel_lo;
      end
    end
  end

  assign bus.MultStart  = (state == START) && !sel;
  assign bus.DivStart   = (state == START) && sel;
  assign bus.Busy       = (state != IDLE);
  assign bus.Done       = (state == DONE);
  assign bus.HI         = hi_r;
  assign bus.LO         = lo_r;
  assign bus.DivZeroExc = zexc_r;
  assign bus.TimeoutExc = texc_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with small behavioural mult/div models.
module tb_hilo_unit;

  localparam int unsigned TO = 48;

  logic Clock = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  hilo_unit_if bus ();

  hilo_unit #(.TIMEOUT(TO)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Divider model: DivStop held stale (high) from a previous op until DivStart.
  int          div_lat     = 32;
  int          div_zero_at = 0;
  int          m_div_cnt   = 0;
  logic        m_div_stop  = 1'b1;
  logic        m_div_zero  = 1'b0;
  logic [31:0] div_hi_val  = '0;
  logic [31:0] div_lo_val  = '0;

  always @(posedge Clock) begin
    if (bus.DivStart) begin
      m_div_stop <= 1'b0;
      m_div_zero <= 1'b0;
      m_div_cnt  <= 1;
    end else if (m_div_cnt > 0) begin
      m_div_cnt <= m_div_cnt + 1;
      if (m_div_cnt == div_lat - 1) begin
        m_div_stop <= 1'b1;
        m_div_cnt  <= 0;
      end
      if (div_zero_at > 0 && m_div_cnt == div_zero_at) begin
        m_div_zero <= 1'b1;
        m_div_cnt  <= 0;
      end
    end
  end

  // Multiplier model: mult_lat == 0 means the unit never finishes.
  int          mult_lat    = 5;
  int          m_mult_cnt  = 0;
  logic        m_mult_stop = 1'b0;
  logic [31:0] mult_hi_val = '0;
  logic [31:0] mult_lo_val = '0;

  always @(posedge Clock) begin
    if (bus.MultStart) begin
      m_mult_stop <= 1'b0;
      m_mult_cnt  <= 1;
    end else if (m_mult_cnt > 0) begin
      m_mult_cnt <= m_mult_cnt + 1;
      if (mult_lat > 0 && m_mult_cnt == mult_lat - 1) begin
        m_mult_stop <= 1'b1;
        m_mult_cnt  <= 0;
      end
    end
  end

  assign bus.DivStop  = m_div_stop;
  assign bus.DivZero  = m_div_zero;
  assign bus.DivHI    = div_hi_val;
  assign bus.DivLO    = div_lo_val;
  assign bus.MultStop = m_mult_stop;
  assign bus.MultHI   = mult_hi_val;
  assign bus.MultLO   = mult_lo_val;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Issue OpStart in the current (IDLE) cycle and check n cycles; cycle 1 is START.
  // Zero event index means "never". inj > 0 drops a WrHI + OpStart into that cycle.
  task automatic run_op(input logic sel, input int n, input int e_done,
                        input int e_zexc, input int e_texc, input int inj,
                        input logic [31:0] res_hi, input logic [31:0] res_lo);
    int idle_at;
    idle_at = (e_done > 0) ? e_done + 1 : ((e_zexc > 0) ? e_zexc : e_texc);
    bus.OpStart = 1'b1;
    bus.OpSel   = sel;
    step();
    bus.OpStart = 1'b0;
    bus.OpSel   = ~sel;
    bus.WrHI    = 1'b0;
    bus.WrLO    = 1'b0;
    for (int i = 1; i <= n; i++) begin
      chk1("DivStart",   bus.DivStart,   (i == 1) && sel);
      chk1("MultStart",  bus.MultStart,  (i == 1) && !sel);
      chk1("Busy",       bus.Busy,       i < idle_at);
      chk1("Done",       bus.Done,       i == e_done);
      chk1("DivZeroExc", bus.DivZeroExc, i == e_zexc);
      chk1("TimeoutExc", bus.TimeoutExc, i == e_texc);
      if (i == 1) begin
        chk("HI_at_start", bus.HI, cur_hi);
        chk("LO_at_start", bus.LO, cur_lo);
      end
      if (i == e_done) begin
        cur_hi = res_hi;
        cur_lo = res_lo;
        chk("HI_at_done", bus.HI, cur_hi);
        chk("LO_at_done", bus.LO, cur_lo);
      end
      if (i == inj) begin
        bus.WrHI    = 1'b1;
        bus.WrData  = 32'hCAFEF00D;
        bus.OpStart = 1'b1;
        bus.OpSel   = sel;
      end else begin
        bus.WrHI    = 1'b0;
        bus.OpStart = 1'b0;
      end
      if (i < n) step();
    end
    chk("HI_at_end", bus.HI, cur_hi);
    chk("LO_at_end", bus.LO, cur_lo);
  endtask

  typedef struct {
    logic        wh;
    logic        wl;
    logic [31:0] d;
    logic [31:0] ehi;
    logic [31:0] elo;
  } wr_vec_t;

  wr_vec_t wv [6];

  initial begin
    wv[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
    wv[1] = '{1'b0, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
    wv[2] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678};
    wv[3] = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    wv[4] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hA5A5A5A5};
    wv[5] = '{1'b0, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678};

    Reset       = 1'b1;
    bus.OpStart = 1'b0;
    bus.OpSel   = 1'b0;
    bus.WrHI    = 1'b0;
    bus.WrLO    = 1'b0;
    bus.WrData  = '0;
    step();
    step();
    Reset = 1'b0;

    // Reset state and quiet idle.
    for (int i = 0; i < 10; i++) begin
      chk("rst_HI", bus.HI, 32'h0);
      chk("rst_LO", bus.LO, 32'h0);
      chk1("rst_Busy",  bus.Busy, 1'b0);
      chk1("rst_Done",  bus.Done, 1'b0);
      chk1("rst_Start", bus.MultStart | bus.DivStart, 1'b0);
      chk1("rst_Exc",   bus.DivZeroExc | bus.TimeoutExc, 1'b0);
      step();
    end

    // mthi / mtlo table.
    for (int i = 0; i < 6; i++) begin
      bus.WrHI   = wv[i].wh;
      bus.WrLO   = wv[i].wl;
      bus.WrData = wv[i].d;
      step();
      bus.WrHI = 1'b0;
      bus.WrLO = 1'b0;
      chk("wr_HI", bus.HI, wv[i].ehi);
      chk("wr_LO", bus.LO, wv[i].elo);
      chk1("wr_Busy", bus.Busy, 1'b0);
    end
    cur_hi = 32'hDEADBEEF;
    cur_lo = 32'h12345678;

    // Div 100/7 with a simultaneous mtlo; stale DivStop during START.
    div_hi_val  = 32'd2;
    div_lo_val  = 32'd14;
    div_lat     = 32;
    div_zero_at = 0;
    mult_hi_val = 32'h77777777;
    bus.WrLO    = 1'b1;
    bus.WrData  = 32'h55AA55AA;
    cur_lo      = 32'h55AA55AA;
    run_op(1'b1, 35, 34, 0, 0, 0, 32'd2, 32'd14);

    // Back-to-back: divide by zero seen in the second WAIT cycle.
    div_hi_val  = 32'hBADBAD00;
    div_lo_val  = 32'hBADBAD01;
    div_lat     = 1000;
    div_zero_at = 1;
    run_op(1'b1, 8, 0, 4, 0, 0, 32'h0, 32'h0);

    // Mult with dropped WrHI/OpStart during WAIT; stale DivZero ignored.
    mult_hi_val = 32'h00000001;
    mult_lo_val = 32'h80000000;
    mult_lat    = 5;
    run_op(1'b0, 10, 7, 0, 0, 3, 32'h00000001, 32'h80000000);

    // Hung multiplier: timeout after TO WAIT cycles.
    mult_hi_val = 32'h99999999;
    mult_lo_val = 32'h99999999;
    mult_lat    = 0;
    run_op(1'b0, TO + 4, 0, 0, TO + 2, 0, 32'h0, 32'h0);

    // Reset in the middle of WAIT: silent abort, registers cleared.
    bus.OpStart = 1'b1;
    bus.OpSel   = 1'b0;
    step();
    bus.OpStart = 1'b0;
    step();
    step();
    step();
    chk1("midrst_Busy_before", bus.Busy, 1'b1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < int'(TO) + 6; i++) begin
      chk("midrst_HI", bus.HI, 32'h0);
      chk("midrst_LO", bus.LO, 32'h0);
      chk1("midrst_Busy",  bus.Busy, 1'b0);
      chk1("midrst_Done",  bus.Done, 1'b0);
      chk1("midrst_Start", bus.MultStart | bus.DivStart, 1'b0);
      chk1("midrst_Exc",   bus.DivZeroExc | bus.TimeoutExc, 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register unit sitting directly downstream of the divider and multiplier in the multicycle MIPS datapath. It launches a mult or div operation on request from the control unit, waits for the selected unit's stop flag, and captures that unit's 32-bit HI and LO results into the architectural HI/LO registers. It also serves mthi/mtlo writes, reports busy for mfhi/mflo interlocking, and converts divide-by-zero and hung-unit conditions into one-cycle exception pulses.

## Interface
- TIMEOUT, 48: maximum WAIT cycles before the operation is abandoned (≥ 34).
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- OpStart  in  1  one-cycle request to start an operation; honoured only in IDLE.
- OpSel  in  1  0 = mult, 1 = div; sampled with OpStart.
- MultStart  out  1  one-cycle start pulse to the multiplier.
- MultStop  in  1  multiplier done flag, level.
- MultHI, MultLO  in  32  multiplier result halves.
- DivStart  out  1  one-cycle start pulse to the divider.
- DivStop  in  1  divider done flag, level, held until the next DivStart.
- DivZero  in  1  divider divide-by-zero flag.
- DivHI, DivLO  in  32  remainder / quotient.
- WrHI, WrLO  in  1  mthi / mtlo write strobes; honoured only in IDLE.
- WrData  in  32  data for WrHI/WrLO.
- HI, LO  out  32  architectural HI/LO registers.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when HI/LO have been updated by an operation.
- DivZeroExc  out  1  one-cycle pulse on divide-by-zero abort.
- TimeoutExc  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: OpStart=1 → latch OpSel into internal sel, go to START. WrHI/WrLO write WrData into HI/LO in the same edge; both strobes may be set together (both registers get WrData). If OpStart and a write arrive together, the write is performed and the operation also starts.
- START (1 cycle): MultStart=1 if sel=0, else DivStart=1. Wait counter cleared to 0. Next state WAIT. Stop/zero inputs are ignored in START, because DivStop/MultStop are still stale from the previous operation.
- WAIT: counter increments each cycle. Priority order, evaluated each edge:
  - 1. sel=1 and DivZero=1 → DivZeroExc pulse, HI/LO unchanged, go to IDLE.
  - 2. the selected Stop=1 → load HI←selected HI, LO←selected LO, go to DONE.
  - 3. counter = TIMEOUT−1 → TimeoutExc pulse, HI/LO unchanged, go to IDLE.
- The non-selected unit's Stop, Zero and result inputs are ignored in all states.
- DONE (1 cycle): Done=1, then go to IDLE.
- OpStart, WrHI and WrLO are dropped silently in START, WAIT and DONE.
- Results are copied bit-exact; this block performs no sign correction.

## Timing
- Reset: state=IDLE, HI=LO=0, counter=0, and every output pulse and Busy = 0. Reset mid-operation aborts immediately with no exception pulse. Start outputs are low in the cycle after the reset edge.
- All outputs are registered or decoded from the state; there are no combinational input-to-output paths.
- An OpStart at edge n gives START in cycle n+1 (start pulse high), and WAIT from n+2.
- A Stop first seen high at edge m gives HI/LO updated and Done=1 in cycle m+1, and IDLE with Busy=0 in cycle m+2.
- Minimum OpStart-to-Done latency is 3 cycles, reached with an immediate Stop.
- A new OpStart is accepted in the first IDLE cycle after DONE, which lets operations run back to back.
- Exception pulses are high in the first IDLE cycle after the abort edge.

## Test plan
- Reset then idle: HI=LO=0, Busy=0, and no pulses during 10 cycles.
- mthi/mtlo: WrHI with 0xDEADBEEF, then WrLO with 0x12345678 → HI=0xDEADBEEF, LO=0x12345678 one cycle after each strobe.
- Div 100/7 with a divider model stopping 32 cycles after DivStart, DivHI=2, DivLO=14 → one DivStart pulse, Busy high throughout, Done pulse, HI=2, LO=14. MultStart stays low, and a stale DivStop=1 during START is ignored.
- Mult with model MultHI=0x1, MultLO=0x80000000 after 5 cycles → HI=0x1, LO=0x80000000. A WrHI and a second OpStart issued during WAIT are dropped.
- DivZero raised in the second WAIT cycle → DivZeroExc pulse, no Done, HI/LO keep their prior values, Busy=0 one cycle later.
- Timeout: mult with MultStop held low → TimeoutExc exactly TIMEOUT WAIT cycles after START. In a separate run, Reset mid-WAIT → IDLE, HI=LO=0, and no exception pulse.
